// File: rtl/csr_file_pkg.sv
// Shared constants, port structs and address decode helper for the machine-mode CSR file.
package csr_file_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MIMPID    = 12'hF13;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   localparam logic [31:0] MISA_VALUE = 32'h4000_1100;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIE_MSIE     = 3;
   localparam int MIE_MTIE     = 7;
   localparam int MIE_MEIE     = 11;
   localparam logic [31:0] MIE_MASK = (32'd1 << MIE_MEIE) | (32'd1 << MIE_MTIE) | (32'd1 << MIE_MSIE);

   typedef struct packed {
      logic [11:0] raddr;
      logic        wintent;
      logic        wren;
      logic [11:0] waddr;
      logic [31:0] wdata;
      logic        inst_ret;
      logic        exception;
      logic [31:0] epc;
      logic [31:0] ecause;
      logic [31:0] etval;
      logic        mret;
      logic        meip;
      logic        mtip;
      logic        msip;
   } csr_file_in_type;

   typedef struct packed {
      logic [31:0] rdata;
      logic        illegal;
      logic        irq;
      logic [31:0] tvec;
      logic [31:0] mepc_o;
   } csr_file_out_type;

   function automatic logic csr_implemented(input logic [11:0] addr);
      case (addr)
         CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
         CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET,
         CSR_MINSTRETH, CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH,
         CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/csr_file_if.sv
// Bundles the pipeline-side request and response of the CSR file.
// Reads are combinational on req.raddr; req.wren commits req.wdata to req.waddr at the next edge.
interface csr_file_if;
   csr_file_pkg::csr_file_in_type  req;
   csr_file_pkg::csr_file_out_type rsp;

   modport master (output req, input rsp);
   modport slave  (input req, output rsp);
endinterface

// File: rtl/csr_file_counter.sv
// 64-bit wrapping counter; any half-write replaces that half and suppresses the increment.
module csr_counter (
   input  logic        clock,
   input  logic        reset,
   input  logic        inc_i,
   input  logic        wr_lo_i,
   input  logic        wr_hi_i,
   input  logic [31:0] wdata_i,
   output logic [63:0] value_o
);
   logic [63:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (wr_lo_i || wr_hi_i) begin
         if (wr_lo_i) count_d[31:0]  = wdata_i;
         if (wr_hi_i) count_d[63:32] = wdata_i;
      end else if (inc_i) begin
         count_d = count_q + 64'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign value_o = count_q;
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read port, next-edge commit, trap state,
// cycle/instret counters and interrupt request.
module csr_file
   import csr_file_pkg::*;
#(
   parameter logic [31:0] HARTID      = 32'h0,
   parameter logic [31:0] MTVEC_RESET = 32'h0
) (
   input logic        clock,
   input logic        reset,
   csr_file_if.slave  bus
);
   csr_file_in_type  req;
   csr_file_out_type rsp;

   logic        mie_en_q, mie_en_d;
   logic        mpie_q, mpie_d;
   logic [31:0] mie_q, mie_d;
   logic [29:0] mtvec_base_q, mtvec_base_d;
   logic        mtvec_mode_q, mtvec_mode_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;
   logic [63:0] mcycle, minstret;
   logic [31:0] mstatus_rd, mip_rd, mtvec_rd, tvec_base;

   assign req = bus.req;

   csr_counter u_mcycle (
      .clock(clock), .reset(reset), .inc_i(1'b1),
      .wr_lo_i(req.wren && req.waddr == CSR_MCYCLE),
      .wr_hi_i(req.wren && req.waddr == CSR_MCYCLEH),
      .wdata_i(req.wdata), .value_o(mcycle)
   );

   csr_counter u_minstret (
      .clock(clock), .reset(reset), .inc_i(req.inst_ret),
      .wr_lo_i(req.wren && req.waddr == CSR_MINSTRET),
      .wr_hi_i(req.wren && req.waddr == CSR_MINSTRETH),
      .wdata_i(req.wdata), .value_o(minstret)
   );

   // Applied lowest priority first so trap entry and mret overwrite only the fields they own.
   always_comb begin
      mie_en_d     = mie_en_q;
      mpie_d       = mpie_q;
      mie_d        = mie_q;
      mtvec_base_d = mtvec_base_q;
      mtvec_mode_d = mtvec_mode_q;
      mscratch_d   = mscratch_q;
      mepc_d       = mepc_q;
      mcause_d     = mcause_q;
      mtval_d      = mtval_q;
      if (req.wren) begin
         case (req.waddr)
            CSR_MSTATUS: begin
               mie_en_d = req.wdata[MSTATUS_MIE];
               mpie_d   = req.wdata[MSTATUS_MPIE];
            end
            CSR_MIE:      mie_d = req.wdata & MIE_MASK;
            CSR_MTVEC: begin
               mtvec_base_d = req.wdata[31:2];
               mtvec_mode_d = (req.wdata[1:0] == 2'b01);
            end
            CSR_MSCRATCH: mscratch_d = req.wdata;
            CSR_MEPC:     mepc_d     = req.wdata & ~32'h3;
            CSR_MCAUSE:   mcause_d   = req.wdata;
            CSR_MTVAL:    mtval_d    = req.wdata;
            default: ;
         endcase
      end
      if (req.mret) begin
         mie_en_d = mpie_q;
         mpie_d   = 1'b1;
      end
      if (req.exception) begin
         mepc_d   = req.epc & ~32'h3;
         mcause_d = req.ecause;
         mtval_d  = req.etval;
         mpie_d   = mie_en_q;
         mie_en_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mie_en_q     <= 1'b0;
         mpie_q       <= 1'b0;
         mie_q        <= '0;
         mtvec_base_q <= MTVEC_RESET[31:2];
         mtvec_mode_q <= (MTVEC_RESET[1:0] == 2'b01);
         mscratch_q   <= '0;
         mepc_q       <= '0;
         mcause_q     <= '0;
         mtval_q      <= '0;
      end else begin
         mie_en_q     <= mie_en_d;
         mpie_q       <= mpie_d;
         mie_q        <= mie_d;
         mtvec_base_q <= mtvec_base_d;
         mtvec_mode_q <= mtvec_mode_d;
         mscratch_q   <= mscratch_d;
         mepc_q       <= mepc_d;
         mcause_q     <= mcause_d;
         mtval_q      <= mtval_d;
      end
   end

   always_comb begin
      mstatus_rd = 32'h0000_1800;
      mstatus_rd[MSTATUS_MIE]  = mie_en_q;
      mstatus_rd[MSTATUS_MPIE] = mpie_q;
      mip_rd = '0;
      mip_rd[MIE_MEIE] = req.meip;
      mip_rd[MIE_MTIE] = req.mtip;
      mip_rd[MIE_MSIE] = req.msip;
   end

   assign tvec_base = {mtvec_base_q, 2'b00};
   assign mtvec_rd  = {mtvec_base_q, 1'b0, mtvec_mode_q};

   always_comb begin
      rsp.rdata = '0;
      case (req.raddr)
         CSR_MSTATUS:               rsp.rdata = mstatus_rd;
         CSR_MISA:                  rsp.rdata = MISA_VALUE;
         CSR_MIE:                   rsp.rdata = mie_q;
         CSR_MTVEC:                 rsp.rdata = mtvec_rd;
         CSR_MSCRATCH:              rsp.rdata = mscratch_q;
         CSR_MEPC:                  rsp.rdata = mepc_q;
         CSR_MCAUSE:                rsp.rdata = mcause_q;
         CSR_MTVAL:                 rsp.rdata = mtval_q;
         CSR_MIP:                   rsp.rdata = mip_rd;
         CSR_MCYCLE,   CSR_CYCLE:   rsp.rdata = mcycle[31:0];
         CSR_MCYCLEH,  CSR_CYCLEH:  rsp.rdata = mcycle[63:32];
         CSR_MINSTRET, CSR_INSTRET: rsp.rdata = minstret[31:0];
         CSR_MINSTRETH,CSR_INSTRETH:rsp.rdata = minstret[63:32];
         CSR_MHARTID:               rsp.rdata = HARTID;
         default:                   rsp.rdata = '0;
      endcase
      rsp.illegal = !csr_implemented(req.raddr) || (req.wintent && req.raddr[11:10] == 2'b11);
      rsp.irq     = mie_en_q && |(mie_q & mip_rd);
      rsp.tvec    = (mtvec_mode_q && req.ecause[31])
                    ? tvec_base + {25'b0, req.ecause[4:0], 2'b00} : tvec_base;
      rsp.mepc_o  = mepc_q;
   end

   assign bus.rsp = rsp;
endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: reset vector table, directed corner sequences,
// then randomized traffic against an architectural model of the CSR state.
module tb_csr_file;
  localparam logic [31:0] TB_HARTID = 32'h0000_0003;
  localparam logic [31:0] TB_MTVEC  = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;

  csr_file_if bus ();
  csr_file #(.HARTID(TB_HARTID), .MTVEC_RESET(TB_MTVEC)) dut (.clock(clk), .reset(rst), .bus(bus));

  int n_checks = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // architectural model
  bit          m_mie_en, m_mpie;
  logic [31:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ins;

  typedef struct {
    logic [11:0] addr;
    logic        wintent;
    logic        chk_data;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic rdchk(input string name, input logic [11:0] a, input logic [31:0] exp);
    bus.req.raddr = a;
    #1;
    chk(name, bus.rsp.rdata, exp);
  endtask

  function automatic void m_reset();
    m_mie_en = 0; m_mpie = 0; m_mie = 0; m_mtvec = TB_MTVEC;
    m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
  endfunction

  function automatic void m_read(input logic [11:0] a, output bit ok, output logic [31:0] v);
    logic [31:0] mip;
    mip = (32'(bus.req.meip) << 11) | (32'(bus.req.mtip) << 7) | (32'(bus.req.msip) << 3);
    ok = 1; v = 0;
    case (a)
      12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie_en) << 3);
      12'h301: v = 32'h4000_1100;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = mip;
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ins[31:0];
      12'hB82, 12'hC82: v = m_ins[63:32];
      12'hF11, 12'hF12, 12'hF13: v = 0;
      12'hF14: v = TB_HARTID;
      default: ok = 0;
    endcase
  endfunction

  // One clock edge of architectural behaviour for the inputs currently applied.
  function automatic void m_update();
    logic        we;
    logic [11:0] wa;
    logic [31:0] wd;
    bit          nie, npie;
    we = bus.req.wren; wa = bus.req.waddr; wd = bus.req.wdata;
    nie = m_mie_en; npie = m_mpie;
    if (we && wa == 12'hB00)      m_cyc[31:0]  = wd;
    else if (we && wa == 12'hB80) m_cyc[63:32] = wd;
    else                          m_cyc = m_cyc + 1;
    if (we && wa == 12'hB02)      m_ins[31:0]  = wd;
    else if (we && wa == 12'hB82) m_ins[63:32] = wd;
    else if (bus.req.inst_ret)    m_ins = m_ins + 1;
    if (bus.req.exception) begin
      npie = m_mie_en; nie = 0;
      m_mepc = bus.req.epc & 32'hFFFF_FFFC;
      m_mcause = bus.req.ecause;
      m_mtval = bus.req.etval;
    end else if (bus.req.mret) begin
      nie = m_mpie; npie = 1;
    end else if (we && wa == 12'h300) begin
      nie = wd[3]; npie = wd[7];
    end
    if (we && !bus.req.exception) begin
      if (wa == 12'h341) m_mepc = wd & 32'hFFFF_FFFC;
      if (wa == 12'h342) m_mcause = wd;
      if (wa == 12'h343) m_mtval = wd;
    end
    if (we && wa == 12'h304) m_mie = wd & 32'h0000_0888;
    if (we && wa == 12'h305) m_mtvec = (wd & 32'hFFFF_FFFC) | ((wd % 4 == 1) ? 32'd1 : 32'd0);
    if (we && wa == 12'h340) m_mscratch = wd;
    m_mie_en = nie; m_mpie = npie;
  endfunction

  function automatic logic [31:0] m_tvec();
    logic [31:0] base;
    base = m_mtvec & 32'hFFFF_FFFC;
    if (m_mtvec % 4 == 1 && bus.req.ecause[31]) return base + 4 * (bus.req.ecause % 32);
    return base;
  endfunction

  function automatic logic m_irq();
    bit ok;
    logic [31:0] mip;
    m_read(12'h344, ok, mip);
    return m_mie_en && ((m_mie & mip) != 0);
  endfunction

  task automatic clr_pulses();
    bus.req.wren = 0; bus.req.exception = 0; bus.req.mret = 0; bus.req.inst_ret = 0;
    bus.req.wintent = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_update();
    @(negedge clk);
    clr_pulses();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.req.wren = 1; bus.req.waddr = a; bus.req.wdata = d;
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    clr_pulses();
    m_reset();
    #10;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    bit          ok;
    logic [31:0] v, base_c;
    logic [11:0] rlist[25];
    logic [11:0] wlist[20];

    bus.req = '0;
    m_reset();

    vecs[0]  = '{12'h300, 0, 1, 32'h0000_1800, 0};
    vecs[1]  = '{12'h301, 0, 1, 32'h4000_1100, 0};
    vecs[2]  = '{12'h304, 0, 1, 32'h0, 0};
    vecs[3]  = '{12'h305, 0, 1, TB_MTVEC, 0};
    vecs[4]  = '{12'h340, 0, 1, 32'h0, 0};
    vecs[5]  = '{12'h341, 0, 1, 32'h0, 0};
    vecs[6]  = '{12'h342, 0, 1, 32'h0, 0};
    vecs[7]  = '{12'h343, 0, 1, 32'h0, 0};
    vecs[8]  = '{12'h344, 0, 1, 32'h0, 0};
    vecs[9]  = '{12'hB00, 0, 1, 32'h0, 0};
    vecs[10] = '{12'hB80, 0, 1, 32'h0, 0};
    vecs[11] = '{12'hC00, 1, 1, 32'h0, 1};
    vecs[12] = '{12'hF14, 0, 1, TB_HARTID, 0};
    vecs[13] = '{12'hF11, 1, 1, 32'h0, 1};
    vecs[14] = '{12'h7C0, 0, 0, 32'h0, 1};
    vecs[15] = '{12'h300, 1, 1, 32'h0000_1800, 0};

    // reset held: combinational read-out of reset state
    @(negedge clk);
    foreach (vecs[i]) begin
      bus.req.raddr = vecs[i].addr;
      bus.req.wintent = vecs[i].wintent;
      #1;
      if (vecs[i].chk_data) chk($sformatf("rst_rdata[%0d]", i), bus.rsp.rdata, vecs[i].exp_rdata);
      chk($sformatf("rst_illegal[%0d]", i), 32'(bus.rsp.illegal), 32'(vecs[i].exp_ill));
    end
    bus.req.wintent = 0;
    chk("rst_irq", 32'(bus.rsp.irq), 0);
    chk("rst_mepc_o", bus.rsp.mepc_o, 0);
    chk("rst_tvec", bus.rsp.tvec, TB_MTVEC);

    // release; first increment at first edge after deassertion
    rst = 0;
    rdchk("mcycle_after_release", 12'hB00, 0);
    tick();
    rdchk("mcycle_one_edge", 12'hB00, 1);

    // vectored mtvec
    wr(12'h305, 32'h8000_0101);
    bus.req.ecause = 32'h8000_0007; #1;
    chk("tvec_vectored", bus.rsp.tvec, 32'h8000_011C);
    bus.req.ecause = 32'h0000_0002; #1;
    chk("tvec_sync", bus.rsp.tvec, 32'h8000_0100);
    bus.req.wren = 1; bus.req.waddr = 12'h305; bus.req.wdata = 32'h8000_0102;
    rdchk("mtvec_old_during_write", 12'h305, 32'h8000_0101);
    tick();
    rdchk("mtvec_mode2", 12'h305, 32'h8000_0100);

    // trap and return
    wr(12'h300, 32'h8);
    bus.req.exception = 1; bus.req.epc = 32'h0000_1236; bus.req.ecause = 2; bus.req.etval = 32'hDEAD;
    tick();
    rdchk("trap_mepc", 12'h341, 32'h0000_1234);
    chk("trap_mepc_o", bus.rsp.mepc_o, 32'h0000_1234);
    rdchk("trap_mcause", 12'h342, 2);
    rdchk("trap_mtval", 12'h343, 32'hDEAD);
    rdchk("trap_mstatus", 12'h300, 32'h0000_1880);
    bus.req.mret = 1;
    tick();
    rdchk("mret_mstatus", 12'h300, 32'h0000_1888);

    // counter carry
    wr(12'hB00, 32'hFFFF_FFFF);
    rdchk("mcycle_lo_written", 12'hB00, 32'hFFFF_FFFF);
    rdchk("mcycleh_before_carry", 12'hB80, 0);
    tick();
    rdchk("mcycle_lo_wrapped", 12'hB00, 0);
    rdchk("mcycleh_carry", 12'hB80, 1);
    rdchk("cycleh_shadow", 12'hC80, 1);
    wr(12'hB02, 32'hFFFF_FFFF);
    rdchk("minstret_written", 12'hB02, 32'hFFFF_FFFF);
    bus.req.inst_ret = 1;
    tick();
    rdchk("minstret_wrapped", 12'hB02, 0);
    rdchk("minstreth_carry", 12'hB82, 1);
    rdchk("instreth_shadow", 12'hC82, 1);

    // interrupt gating
    wr(12'h304, 32'h80);
    wr(12'h300, 32'h8);
    bus.req.mtip = 1; #1;
    chk("irq_mtip", 32'(bus.rsp.irq), 1);
    bus.req.wren = 1; bus.req.waddr = 12'h300; bus.req.wdata = 0; #1;
    chk("irq_still_during_write", 32'(bus.rsp.irq), 1);
    tick();
    chk("irq_gated", 32'(bus.rsp.irq), 0);
    wr(12'h344, 32'hFFFF_FFFF);
    rdchk("mip_ro", 12'h344, 32'h80);
    wr(12'h304, 32'hFFFF_FFFF);
    rdchk("mie_mask", 12'h304, 32'h888);
    bus.req.mtip = 0;

    // illegal access and priority
    bus.req.raddr = 12'h7C0; #1;
    chk("illegal_unimpl", 32'(bus.rsp.illegal), 1);
    bus.req.raddr = 12'hC00; bus.req.wintent = 1; #1;
    chk("illegal_ro_write", 32'(bus.rsp.illegal), 1);
    bus.req.wintent = 0;
    v = m_cyc[31:0];
    bus.req.wren = 1; bus.req.waddr = 12'hC00; bus.req.wdata = 32'h1234_5678;
    rdchk("cycle_before_ro_write", 12'hC00, v);
    tick();
    rdchk("cycle_after_ro_write", 12'hB00, v + 1);
    bus.req.wren = 1; bus.req.waddr = 12'h341; bus.req.wdata = 32'h5550;
    bus.req.exception = 1; bus.req.epc = 32'h9998; bus.req.ecause = 3; bus.req.etval = 0;
    tick();
    rdchk("exc_beats_wren_mepc", 12'h341, 32'h9998);
    bus.req.wren = 1; bus.req.waddr = 12'h340; bus.req.wdata = 32'hABCD;
    bus.req.exception = 1; bus.req.epc = 32'h40;
    tick();
    rdchk("mscratch_in_trap", 12'h340, 32'hABCD);
    wr(12'h300, 32'h80);
    bus.req.wren = 1; bus.req.waddr = 12'h300; bus.req.wdata = 32'h0; bus.req.mret = 1;
    tick();
    rdchk("mret_beats_wren", 12'h300, 32'h1888);

    // randomized traffic against the model
    do_reset();
    rlist = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
              12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
              12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h345, 12'hB01, 12'hF15};
    wlist = '{12'h300, 12'h300, 12'h304, 12'h304, 12'h305, 12'h305, 12'h340, 12'h341,
              12'h342, 12'h343, 12'h344, 12'h301, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
              12'hC00, 12'hF14, 12'h7C0, 12'h300};
    for (int c = 0; c < 600; c++) begin
      bus.req.raddr     = rlist[$urandom_range(0, 24)];
      bus.req.wintent   = 1'($urandom_range(0, 1));
      bus.req.wren      = ($urandom_range(0, 2) == 0);
      bus.req.waddr     = wlist[$urandom_range(0, 19)];
      bus.req.wdata     = $urandom;
      bus.req.inst_ret  = 1'($urandom_range(0, 1));
      bus.req.exception = ($urandom_range(0, 9) == 0);
      bus.req.mret      = ($urandom_range(0, 7) == 0);
      bus.req.epc       = $urandom;
      bus.req.ecause    = $urandom;
      bus.req.etval     = $urandom;
      bus.req.meip      = 1'($urandom_range(0, 1));
      bus.req.mtip      = 1'($urandom_range(0, 1));
      bus.req.msip      = 1'($urandom_range(0, 1));
      #1;
      m_read(bus.req.raddr, ok, v);
      if (ok) begin
        exp_q.push_back(v);
        chk($sformatf("rnd_rdata[%0d]@%03h", c, bus.req.raddr), bus.rsp.rdata, exp_q.pop_front());
      end
      chk($sformatf("rnd_illegal[%0d]", c), 32'(bus.rsp.illegal),
          32'(!ok || (bus.req.wintent && bus.req.raddr >= 12'hC00)));
      chk($sformatf("rnd_irq[%0d]", c), 32'(bus.rsp.irq), 32'(m_irq()));
      chk($sformatf("rnd_tvec[%0d]", c), bus.rsp.tvec, m_tvec());
      chk($sformatf("rnd_mepc_o[%0d]", c), bus.rsp.mepc_o, m_mepc);
      tick();
    end

    // asynchronous reset mid-cycle
    bus.req = '0;
    wr(12'h300, 32'h88);
    base_c = 32'h0;
    #5;
    rst = 1;
    m_reset();
    bus.req.raddr = 12'h300; #1;
    chk("async_rst_mstatus", bus.rsp.rdata, 32'h1800);
    bus.req.raddr = 12'hB00; #1;
    chk("async_rst_mcycle", bus.rsp.rdata, base_c);
    @(negedge clk);
    rst = 0;
    tick();
    rdchk("post_async_mcycle", 12'hB00, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
